// File: rtl/loop_index_gen.sv
// loop_index_gen: two-level (outer/inner) index sequencer emitting row-major pairs on a valid/ready stream
module loop_index_gen #(
    parameter int OUTER_WIDTH = 8,
    parameter int INNER_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [OUTER_WIDTH-1:0] outer_last,
    input  logic [INNER_WIDTH-1:0] inner_last,
    output logic                   idx_valid,
    input  logic                   idx_ready,
    output logic [OUTER_WIDTH-1:0] outer_idx,
    output logic [INNER_WIDTH-1:0] inner_idx,
    output logic                   idx_row_end,
    output logic                   idx_end,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
    state_t                 state_q, state_d;
    logic [OUTER_WIDTH-1:0] outer_q, outer_d, outer_last_q, outer_last_d;
    logic [INNER_WIDTH-1:0] inner_q, inner_d, inner_last_q, inner_last_d;
    logic                   run, beat, row_end, job_end;
    assign run     = state_q == RUN;
    assign beat    = run && idx_ready;
    assign row_end = inner_q == inner_last_q;
    assign job_end = row_end && outer_q == outer_last_q;
    // next state, index stepping and terminal latching
    always_comb begin
        state_d      = state_q;
        outer_d      = outer_q;
        inner_d      = inner_q;
        outer_last_d = outer_last_q;
        inner_last_d = inner_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    outer_last_d = outer_last;
                    inner_last_d = inner_last;
                    outer_d      = '0;
                    inner_d      = '0;
                end
            end
            RUN: begin
                if (beat) begin
                    if (!row_end) begin
                        inner_d = inner_q + 1'b1;
                    end else if (!job_end) begin
                        inner_d = '0;
                        outer_d = outer_q + 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                    outer_d = '0;
                    inner_d = '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and index registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            outer_q      <= '0;
            inner_q      <= '0;
            outer_last_q <= '0;
            inner_last_q <= '0;
        end else begin
            state_q      <= state_d;
            outer_q      <= outer_d;
            inner_q      <= inner_d;
            outer_last_q <= outer_last_d;
            inner_last_q <= inner_last_d;
        end
    end
    assign idx_valid   = run;
    assign busy        = run;
    assign done        = state_q == DONE;
    assign outer_idx   = outer_q;
    assign inner_idx   = inner_q;
    assign idx_row_end = run && row_end;
    assign idx_end     = run && job_end;
endmodule

// File: tb/tb_loop_index_gen.sv
// tb_loop_index_gen: table-driven and randomized checks of loop_index_gen against a nested-loop pair list
module tb_loop_index_gen;
    logic       clk = 0, rst_n = 0, start = 0, abort = 0, idx_ready = 0;
    logic [7:0] outer_last = 0, inner_last = 0, outer_idx, inner_idx;
    logic       idx_valid, idx_row_end, idx_end, busy, done;
    logic       s4 = 0, r4 = 0, v4, re4, e4, b4, d4;
    logic [3:0] ol4 = 0, il4 = 0, o4, i4;
    int         n_pass = 0, n_total = 0;
    typedef struct {int o; int i;} pair_t;
    typedef struct {int ol; int il; int mode; int beats;} vec_t;
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    loop_index_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .outer_last(outer_last), .inner_last(inner_last),
        .idx_valid(idx_valid), .idx_ready(idx_ready),
        .outer_idx(outer_idx), .inner_idx(inner_idx),
        .idx_row_end(idx_row_end), .idx_end(idx_end), .busy(busy), .done(done)
    );

    loop_index_gen #(.OUTER_WIDTH(4), .INNER_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .abort(1'b0),
        .outer_last(ol4), .inner_last(il4),
        .idx_valid(v4), .idx_ready(r4),
        .outer_idx(o4), .inner_idx(i4),
        .idx_row_end(re4), .idx_end(e4), .busy(b4), .done(d4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // mode 0: ready always 1; 1: random ready plus ignored start/terminal noise; 2: fixed ready pattern
    task automatic run_job(input int ol, input int il, input int mode, input int exp_beats);
        pair_t      q[$];
        int         beats = 0, cyc = 0;
        logic       hold = 0;
        logic [7:0] po = 0, pi = 0;
        for (int o = 0; o <= ol; o++)
            for (int i = 0; i <= il; i++) q.push_back('{o, i});
        outer_last = 8'(ol);
        inner_last = 8'(il);
        start = 1;
        step();
        start = 0;
        chk("start_outer", outer_idx, 0);
        chk("start_inner", inner_idx, 0);
        while (q.size() > 0 && cyc < 4000) begin
            idx_ready = mode == 0 ? 1'b1 : mode == 2 ? pat[cyc % 7] : 1'($urandom);
            if (mode == 1) begin
                start = ($urandom % 4) == 0;
                outer_last = 8'($urandom);
                inner_last = 8'($urandom);
            end
            chk("valid_in_run", idx_valid, 1);
            chk("busy_in_run", busy, 1);
            if (hold) begin
                chk("hold_outer", outer_idx, po);
                chk("hold_inner", inner_idx, pi);
            end
            if (idx_ready) begin
                chk("outer", outer_idx, q[0].o);
                chk("inner", inner_idx, q[0].i);
                chk("row_end", idx_row_end, q[0].i == il);
                chk("end", idx_end, q.size() == 1);
                void'(q.pop_front());
                beats++;
            end
            hold = !idx_ready;
            po = outer_idx;
            pi = inner_idx;
            step();
            cyc++;
        end
        start = 0;
        idx_ready = 0;
        chk("beats", beats, exp_beats);
        chk("done_pulse", done, 1);
        chk("valid_off", idx_valid, 0);
        chk("busy_off", busy, 0);
        chk("row_end_off", idx_row_end, 0);
        step();
        chk("done_once", done, 0);
    endtask

    initial begin
        vec_t tbl[6] = '{'{2, 3, 0, 12}, '{0, 0, 0, 1}, '{1, 1, 2, 4},
                         '{0, 5, 1, 6}, '{4, 0, 1, 5}, '{3, 2, 1, 12}};
        int n;
        #3;
        chk("rst_valid", idx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_outer", outer_idx, 0);
        chk("rst_inner", inner_idx, 0);
        @(negedge clk);
        rst_n = 1;
        step();
        for (int k = 0; k < 6; k++) run_job(tbl[k].ol, tbl[k].il, tbl[k].mode, tbl[k].beats);
        // abort in the cycle of the fifth beat
        outer_last = 2;
        inner_last = 3;
        start = 1;
        step();
        start = 0;
        idx_ready = 1;
        for (int k = 0; k < 5; k++) begin
            abort = k == 4;
            chk("abort_outer", outer_idx, k / 4);
            chk("abort_inner", inner_idx, k % 4);
            step();
        end
        abort = 0;
        idx_ready = 0;
        chk("abort_valid", idx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_outer_clr", outer_idx, 0);
        chk("abort_inner_clr", inner_idx, 0);
        step();
        chk("abort_no_done", done, 0);
        run_job(2, 3, 0, 12);
        for (int k = 0; k < 6; k++) begin
            int ol = int'($urandom_range(0, 7)), il = int'($urandom_range(0, 7));
            run_job(ol, il, 1, (ol + 1) * (il + 1));
        end
        // 4-bit instance at full-range terminals
        ol4 = 15;
        il4 = 15;
        s4 = 1;
        step();
        s4 = 0;
        r4 = 1;
        n = 0;
        while (v4 && n < 300) begin
            chk("w4_outer", o4, n / 16);
            chk("w4_inner", i4, n % 16);
            chk("w4_end", e4, n == 255);
            n++;
            step();
        end
        r4 = 0;
        chk("w4_beats", n, 256);
        chk("w4_done", d4, 1);
        step();
        chk("w4_done_once", d4, 0);
        // asynchronous reset mid-job
        outer_last = 3;
        inner_last = 3;
        start = 1;
        step();
        start = 0;
        idx_ready = 1;
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", idx_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_outer", outer_idx, 0);
        chk("arst_inner", inner_idx, 0);
        chk("arst_row_end", idx_row_end, 0);
        rst_n = 1;
        step();
        chk("arst_stay_idle", idx_valid, 0);
        chk("arst_no_done", done, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
